// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync + debounce FSM per button, press pulses, forward/backward arbitration.
// Define BUTTON_CONDITIONER_ATTACK_REPEAT_EN to add attack auto-repeat pulses while attack is held.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_forward_in,
    input  logic btn_backward_in,
    input  logic btn_jump_in,
    input  logic btn_attack_in,
    output logic forward,
    output logic backward,
    output logic jump,
    output logic attack,
    output logic jump_pulse,
    output logic attack_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam int NBTN = 4;
    localparam int FWD  = 0;
    localparam int BWD  = 1;
    localparam int JMP  = 2;
    localparam int ATK  = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  sync1_q, sync1_d;
    logic [NBTN-1:0]  sync2_q, sync2_d;
    state_t           state_q [NBTN];
    state_t           state_d [NBTN];
    logic [CNT_W-1:0] cnt_q [NBTN];
    logic [CNT_W-1:0] cnt_d [NBTN];
    logic [NBTN-1:0]  level_q, level_d;
    logic [NBTN-1:0]  rise;
    logic             last_dir_q, last_dir_d;
    logic             forward_q, forward_d;
    logic             backward_q, backward_d;
    logic             jump_pulse_q, jump_pulse_d;
    logic             attack_pulse_q, attack_pulse_d;
    logic             rpt_fire;

    assign raw = {btn_attack_in, btn_jump_in, btn_backward_in, btn_forward_in};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        rise    = '0;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                        rise[i]    = 1'b1;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = CNT_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == PRESSED) || (state_d[i] == RELEASE_WAIT);
        end
    end

`ifdef BUTTON_CONDITIONER_ATTACK_REPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rpt_q, rpt_d;

    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q[ATK] == PRESSED) begin
            if (rpt_q == RPT_LAST) begin
                rpt_fire = 1'b1;
            end else begin
                rpt_d    = rpt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Most recent direction press wins; a simultaneous rise goes to forward.
    always_comb begin
        last_dir_d = last_dir_q;
        if (rise[FWD]) begin
            last_dir_d = 1'b1;
        end else if (rise[BWD]) begin
            last_dir_d = 1'b0;
        end
        forward_d      = level_q[FWD] & (~level_q[BWD] | last_dir_q);
        backward_d     = level_q[BWD] & (~level_q[FWD] | ~last_dir_q);
        jump_pulse_d   = rise[JMP];
        attack_pulse_d = rise[ATK] | rpt_fire;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            level_q        <= '0;
            last_dir_q     <= 1'b1;
            forward_q      <= 1'b0;
            backward_q     <= 1'b0;
            jump_pulse_q   <= 1'b0;
            attack_pulse_q <= 1'b0;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            level_q        <= level_d;
            last_dir_q     <= last_dir_d;
            forward_q      <= forward_d;
            backward_q     <= backward_d;
            jump_pulse_q   <= jump_pulse_d;
            attack_pulse_q <= attack_pulse_d;
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign forward      = forward_q;
    assign backward     = backward_q;
    assign jump         = level_q[JMP];
    assign attack       = level_q[ATK];
    assign jump_pulse   = jump_pulse_q;
    assign attack_pulse = attack_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
// Inputs change on the falling edge; outputs are compared on the following falling edge.
module tb_button_conditioner;

    logic clk;
    logic rst;
    logic btn_forward_in;
    logic btn_backward_in;
    logic btn_jump_in;
    logic btn_attack_in;
    logic forward;
    logic backward;
    logic jump;
    logic attack;
    logic jump_pulse;
    logic attack_pulse;

    int total;
    int bad;

    // Button vector order {forward, backward, jump, attack};
    // output vector order {forward, backward, jump, attack, jump_pulse, attack_pulse}.
    typedef struct {
        logic [3:0] btn;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(8),
        .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_forward_in(btn_forward_in),
        .btn_backward_in(btn_backward_in),
        .btn_jump_in(btn_jump_in),
        .btn_attack_in(btn_attack_in),
        .forward(forward),
        .backward(backward),
        .jump(jump),
        .attack(attack),
        .jump_pulse(jump_pulse),
        .attack_pulse(attack_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] btn);
        btn_forward_in  = btn[3];
        btn_backward_in = btn[2];
        btn_jump_in     = btn[1];
        btn_attack_in   = btn[0];
    endtask

    task automatic checkOutput(input string name, input int idx, input logic [5:0] exp);
        logic [5:0] act;
        act = {forward, backward, jump, attack, jump_pulse, attack_pulse};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s[%0d]: got %b want %b (fwd,bwd,jmp,atk,jp,ap)", name, idx, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic seqStep(input logic [3:0] btn, input logic [5:0] exp, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            applyStimulus(btn);
            @(negedge clk);
            checkOutput(name, k, exp);
        end
    endtask

    function automatic void addVec(input logic [3:0] btn, input logic [5:0] exp, input int n);
        vec_t v;
        v.btn = btn;
        v.exp = exp;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    initial begin
        int pulses;
        int exp_pulses;
        logic [5:0] e;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        applyStimulus(4'b0000);

        // Table: jump press/release, then a simultaneous direction press with a forward hand-over.
        addVec(4'b0010, 6'b000000, 5);
        addVec(4'b0010, 6'b001010, 1);
        addVec(4'b0010, 6'b001000, 1);
        addVec(4'b0000, 6'b001000, 5);
        addVec(4'b0000, 6'b000000, 1);
        addVec(4'b1100, 6'b000000, 6);
        addVec(4'b1100, 6'b100000, 2);
        addVec(4'b0100, 6'b100000, 6);
        addVec(4'b0100, 6'b010000, 1);
        addVec(4'b0000, 6'b010000, 6);
        addVec(4'b0000, 6'b000000, 1);

        #1 rst = 1'b1;
        #2 checkOutput("reset_async", 0, 6'b000000);
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", 0, 6'b000000);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].btn);
            @(negedge clk);
            checkOutput("vec", i, vecs[i].exp);
        end

        // Long jump hold: single pulse after edge 5, level stays high.
        pulses = 0;
        for (int t = 0; t < 106; t++) begin
            applyStimulus(4'b0010);
            @(negedge clk);
            if (jump_pulse === 1'b1) pulses++;
            checkOutput("jump_hold", t, {2'b00, (t >= 5), 1'b0, (t == 5), 1'b0});
        end
        checkCount("jump_pulse_count", pulses, 1);
        seqStep(4'b0000, 6'b001000, 5, "jump_release");
        seqStep(4'b0000, 6'b000000, 2, "jump_idle");

        // Attack glitch train 1,1,0: never accepted.
        for (int t = 0; t < 40; t++) begin
            applyStimulus({3'b000, (t % 3 != 2)});
            @(negedge clk);
            checkOutput("attack_glitch", t, 6'b000000);
        end
        seqStep(4'b0000, 6'b000000, 3, "glitch_idle");

        // Forward held, backward pressed 20 cycles later, then backward released.
        seqStep(4'b1000, 6'b000000, 6, "fwd_wait");
        seqStep(4'b1000, 6'b100000, 14, "fwd_held");
        seqStep(4'b1100, 6'b100000, 6, "bwd_wait");
        seqStep(4'b1100, 6'b010000, 4, "bwd_wins");
        seqStep(4'b1000, 6'b010000, 6, "bwd_release");
        seqStep(4'b1000, 6'b100000, 2, "fwd_back");
        seqStep(4'b0000, 6'b100000, 6, "fwd_release");
        seqStep(4'b0000, 6'b000000, 2, "dir_idle");

        // Reset in PRESS_WAIT (cnt=2), then in PRESSED; restart needs a full D+2 edges.
        seqStep(4'b0010, 6'b000000, 4, "pw_before_rst");
        #2 rst = 1'b1;
        #1 checkOutput("rst_press_wait", 0, 6'b000000);
        @(negedge clk);
        rst = 1'b0;
        seqStep(4'b0010, 6'b000000, 5, "pw_restart");
        seqStep(4'b0010, 6'b001010, 1, "pw_accept");
        seqStep(4'b0010, 6'b001000, 3, "pw_held");
        #2 rst = 1'b1;
        #1 checkOutput("rst_pressed", 0, 6'b000000);
        @(negedge clk);
        checkOutput("rst_pressed_hold", 0, 6'b000000);
        rst = 1'b0;
        seqStep(4'b0010, 6'b000000, 5, "pr_restart");
        seqStep(4'b0010, 6'b001010, 1, "pr_accept");
        seqStep(4'b0000, 6'b001000, 5, "pr_release");
        seqStep(4'b0000, 6'b000000, 2, "pr_idle");

        // Attack held 40 cycles past acceptance.
        pulses = 0;
`ifdef BUTTON_CONDITIONER_ATTACK_REPEAT_EN
        exp_pulses = 6;
`else
        exp_pulses = 1;
`endif
        for (int t = 0; t < 46; t++) begin
            applyStimulus(4'b0001);
            @(negedge clk);
            if (attack_pulse === 1'b1) pulses++;
            e = {3'b000, (t >= 5), 1'b0, (t == 5)};
`ifdef BUTTON_CONDITIONER_ATTACK_REPEAT_EN
            if (t > 5 && ((t - 5) % 8) == 0) e[0] = 1'b1;
`endif
            checkOutput("attack_hold", t, e);
        end
        checkCount("attack_pulse_count", pulses, exp_pulses);
        seqStep(4'b0000, 6'b000100, 5, "attack_release");
        seqStep(4'b0000, 6'b000000, 2, "attack_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
